ps2_key_decoder: RTL

Converts the raw PS/2 keyboard line into the ten held-key levels that drive the game engine: player 1 arrows + space, player 2 W/A/S/D + enter. It sits between the board `ps2_clk`/`ps2_data` pins and `game_engine`, in the system clock domain `clk`. It handles frame reception, odd-parity checking, the `E0` extended prefix and the `F0` break prefix. Each output is a level: high while the key is held, low after release.

---
 rtl/tank_pkg.sv | 59 +++++
 rtl/ps2_rx.sv | 122 ++++++++++++
 rtl/ps2_key_decoder.sv | 88 ++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// Shared scan codes, key indices and receiver states for the PS/2 key decoder.
package tank_pkg;

  localparam int unsigned NUM_KEYS = 10;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [3:0] {
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT, KEY_SPACE,
    KEY_W, KEY_S, KEY_A, KEY_D, KEY_ENTER
  } key_e;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} ps2_rx_state_e;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_hit_t;

  // Map a non-prefix byte to a key, honouring the E0 extended flag.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.key = KEY_UP;
    if (ext) begin
      case (code)
        SC_UP:    r.key = KEY_UP;
        SC_DOWN:  r.key = KEY_DOWN;
        SC_LEFT:  r.key = KEY_LEFT;
        SC_RIGHT: r.key = KEY_RIGHT;
        SC_ENTER: r.key = KEY_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_SPACE: r.key = KEY_SPACE;
        SC_W:     r.key = KEY_W;
        SC_S:     r.key = KEY_S;
        SC_A:     r.key = KEY_A;
        SC_D:     r.key = KEY_D;
        SC_ENTER: r.key = KEY_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk fall detect, 11-bit frame FSM.
// Optional mid-frame idle abort when PS2_TIMEOUT_EN is defined.
module ps2_rx
  import tank_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic [2:0]    pclk_q;
  logic [1:0]    pdat_q;
  ps2_rx_state_e state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          par_q, par_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          fall_c;
  logic          bit_c;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  assign fall_c = pclk_q[2] & ~pclk_q[1];
  assign bit_c  = pdat_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_q      <= 3'b111;
      pdat_q      <= 2'b11;
      state_q     <= RX_IDLE;
      shift_q     <= 8'h00;
      cnt_q       <= 3'd0;
      par_q       <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      pclk_q      <= {pclk_q[1:0], ps2_clk};
      pdat_q      <= {pdat_q[0], ps2_data};
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      par_q       <= par_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    par_d       = par_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall_c) begin
      case (state_q)
        RX_IDLE: begin
          // A high start bit is a glitch edge, not a frame.
          if (!bit_c) begin
            state_d = RX_DATA;
            cnt_d   = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d = {bit_c, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = bit_c;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (bit_c && (^{shift_q, par_q})) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    tmo_d = '0;
    if ((state_q != RX_IDLE) && !fall_c) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_d     = RX_IDLE;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
`endif
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to ten held-key levels: E0/F0 prefix flags plus key register bank.
// Define PS2_TIMEOUT_EN to enable the receiver mid-frame timeout.
module ps2_key_decoder
  import tank_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       space,
  output logic       w,
  output logic       s,
  output logic       a,
  output logic       d,
  output logic       enter,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err
);

  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  key_hit_t            hit_c;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      keys_q <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      keys_q <= keys_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
    end
  end

  assign hit_c = key_lookup(ext_q, rx_data);

  // A bad frame may have eaten the key code, so drop any pending prefix.
  always_comb begin
    keys_d = keys_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        if (hit_c.hit) keys_d[hit_c.key] = ~brk_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  assign up    = keys_q[KEY_UP];
  assign down  = keys_q[KEY_DOWN];
  assign left  = keys_q[KEY_LEFT];
  assign right = keys_q[KEY_RIGHT];
  assign space = keys_q[KEY_SPACE];
  assign w     = keys_q[KEY_W];
  assign s     = keys_q[KEY_S];
  assign a     = keys_q[KEY_A];
  assign d     = keys_q[KEY_D];
  assign enter = keys_q[KEY_ENTER];

endmodule
